// File: rtl/id_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pipe_pkg
// Description : Shared constants for the ID->EX pipeline register and its
//               bubble sequencer: state encoding, NOP ALU code, link register.
// Revision    : 1.0 - initial release
// ============================================================================
package id_pipe_pkg;

    // Default field widths of the decode bundle
    localparam int c_ctrl_w = 9;
    localparam int c_alu_w  = 6;

    // ALU code presented to EX while a bubble occupies the slot
    localparam logic [5:0] c_nop_alu = 6'h15;

    // Destination register written by jump-and-link instructions
    localparam int c_link_reg = 31;

    // Bubble sequencer state encoding
    typedef logic [0:0] seq_state_t;
    localparam seq_state_t c_st_run  = 1'b0;
    localparam seq_state_t c_st_link = 1'b1;

endpackage : id_pipe_pkg
`default_nettype wire

// File: rtl/id_bubble_seq.sv
`default_nettype none
// ============================================================================
// Module      : id_bubble_seq
// Description : Link-bubble sequencer. After a link op is accepted it holds
//               the pipe in LINK for LINK_BUBBLES cycles, asking the parent
//               to emit a NOP slot and freeze fetch on each of them.
// Revision    : 1.0 - initial release
// ============================================================================
module id_bubble_seq
    import id_pipe_pkg::*;
#(
    parameter int LINK_BUBBLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stall,
    input  logic       i_flush,
    input  logic       i_start_link,
    output seq_state_t o_state,
    output logic       o_lock,
    output logic       o_emit_nop
);

    // Bubble count loaded on link acceptance; zero means no LINK phase at all
    localparam logic [2:0] c_link_cnt = 3'(LINK_BUBBLES);

    seq_state_t r_state;
    logic [2:0] r_cnt;

    // State and down-counter; flush beats stall, and LINK is only entered
    // with a non-zero count so the counter can never wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
            r_cnt   <= 3'd0;
        end else if (i_flush) begin
            r_state <= c_st_run;
            r_cnt   <= 3'd0;
        end else if (i_stall) begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
        end else if (r_state == c_st_link) begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
                r_state <= c_st_run;
            end
        end else if (i_start_link && (c_link_cnt != 3'd0)) begin
            r_cnt   <= c_link_cnt;
            r_state <= c_st_link;
        end
    end

    // Every LINK cycle both freezes fetch and injects a NOP slot
    always_comb begin
        o_state    = r_state;
        o_lock     = (r_state == c_st_link);
        o_emit_nop = (r_state == c_st_link);
    end

endmodule : id_bubble_seq
`default_nettype wire

// File: rtl/id_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_pipe_ctrl
// Description : ID->EX pipeline register with hazard sequencing. Captures the
//               decode bundle each cycle, injects NOP bubbles after link
//               jumps and on load-use hazards, and honours stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module id_pipe_ctrl
    import id_pipe_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                REG_AW       = 5,
    parameter int                CTRL_W       = c_ctrl_w,
    parameter int                ALU_W        = c_alu_w,
    parameter int                DMEM_W       = 3,
    parameter int                LINK_BUBBLES = 2,
    parameter logic [ALU_W-1:0]  NOP_ALU      = c_nop_alu,
    parameter int                LINK_REG     = c_link_reg
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [ALU_W-1:0]  alu_ctrl_in,
    input  logic [DATA_W-1:0] busA_in,
    input  logic [DATA_W-1:0] busB_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DMEM_W-1:0] dmem_info_in,
    input  logic [REG_AW-1:0] rs_in,
    input  logic [REG_AW-1:0] rt_in,
    input  logic              uses_rt_in,
    input  logic [REG_AW-1:0] wr_reg_in,
    input  logic              is_link_in,
    input  logic              is_load_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [ALU_W-1:0]  alu_ctrl_out,
    output logic [DATA_W-1:0] busA_out,
    output logic [DATA_W-1:0] busB_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [DMEM_W-1:0] dmem_info_out,
    output logic [REG_AW-1:0] wr_reg_out,
    output logic              is_load_out,
    output logic              valid_out,
    output logic              lock_if
);

    localparam logic [REG_AW-1:0] c_link_wr = REG_AW'(LINK_REG);

    logic [CTRL_W-1:0] r_ctrl;
    logic [ALU_W-1:0]  r_alu;
    logic [DATA_W-1:0] r_bus_a;
    logic [DATA_W-1:0] r_bus_b;
    logic [DATA_W-1:0] r_imm;
    logic [DMEM_W-1:0] r_dmem;
    logic [REG_AW-1:0] r_wr_reg;
    logic              r_is_load;
    logic              r_valid;

    seq_state_t w_state;
    logic       w_seq_lock;
    logic       w_emit_nop;
    logic       w_hazard;
    logic       w_start_link;
    logic       w_take_nop;

    // Load in EX whose result is needed by the instruction now in decode.
    // r0 never creates a dependency.
    always_comb begin
        w_hazard = (w_state == c_st_run) && r_is_load && r_valid &&
                   (r_wr_reg != '0) &&
                   ((r_wr_reg == rs_in) || (uses_rt_in && (r_wr_reg == rt_in)));
        w_start_link = (w_state == c_st_run) && in_valid && is_link_in && !w_hazard;
        w_take_nop   = w_emit_nop || w_hazard || !in_valid;
        lock_if      = w_seq_lock || w_hazard;
    end

    id_bubble_seq #(
        .LINK_BUBBLES (LINK_BUBBLES)
    ) u_bubble_seq (
        .clk          (clk),
        .rst          (reset),
        .i_stall      (stall_in),
        .i_flush      (flush),
        .i_start_link (w_start_link),
        .o_state      (w_state),
        .o_lock       (w_seq_lock),
        .o_emit_nop   (w_emit_nop)
    );

    // Pipeline register: data fields always follow decode unless held;
    // control fields are replaced by a NOP slot on bubbles and flush
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_alu     <= NOP_ALU;
            r_bus_a   <= '0;
            r_bus_b   <= '0;
            r_imm     <= '0;
            r_dmem    <= '0;
            r_wr_reg  <= '0;
            r_is_load <= 1'b0;
            r_valid   <= 1'b0;
        end else if (flush || !stall_in) begin
            r_bus_a <= busA_in;
            r_bus_b <= busB_in;
            r_imm   <= imm_in;
            r_dmem  <= dmem_info_in;
            if (flush || w_take_nop) begin
                r_ctrl    <= '0;
                r_alu     <= NOP_ALU;
                r_wr_reg  <= '0;
                r_is_load <= 1'b0;
                r_valid   <= 1'b0;
            end else begin
                r_ctrl    <= ctrl_in;
                r_alu     <= alu_ctrl_in;
                r_wr_reg  <= is_link_in ? c_link_wr : wr_reg_in;
                r_is_load <= is_load_in;
                r_valid   <= 1'b1;
            end
        end
    end

    // Registered fields drive EX directly
    always_comb begin
        ctrl_out      = r_ctrl;
        alu_ctrl_out  = r_alu;
        busA_out      = r_bus_a;
        busB_out      = r_bus_b;
        imm_out       = r_imm;
        dmem_info_out = r_dmem;
        wr_reg_out    = r_wr_reg;
        is_load_out   = r_is_load;
        valid_out     = r_valid;
    end

endmodule : id_pipe_ctrl
`default_nettype wire

// File: tb/tb_id_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_pipe_ctrl
// Description : Self-checking bench for id_pipe_ctrl: directed hazard, link,
//               flush and stall scenarios followed by randomized traffic
//               compared against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_pipe_ctrl;

    localparam int         DATA_W = 32;
    localparam int         REG_AW = 5;
    localparam int         CTRL_W = 9;
    localparam int         ALU_W  = 6;
    localparam int         DMEM_W = 3;
    localparam int         LB     = 2;
    localparam logic [5:0] NOP    = 6'h15;

    logic              clk = 1'b0;
    logic              reset, stall_in, flush, in_valid;
    logic [CTRL_W-1:0] ctrl_in;
    logic [ALU_W-1:0]  alu_ctrl_in;
    logic [DATA_W-1:0] busA_in, busB_in, imm_in;
    logic [DMEM_W-1:0] dmem_info_in;
    logic [REG_AW-1:0] rs_in, rt_in, wr_reg_in;
    logic              uses_rt_in, is_link_in, is_load_in;
    logic [CTRL_W-1:0] ctrl_out;
    logic [ALU_W-1:0]  alu_ctrl_out;
    logic [DATA_W-1:0] busA_out, busB_out, imm_out;
    logic [DMEM_W-1:0] dmem_info_out;
    logic [REG_AW-1:0] wr_reg_out;
    logic              is_load_out, valid_out, lock_if;

    always #5 clk = ~clk;

    id_pipe_ctrl #(
        .DATA_W (DATA_W), .REG_AW (REG_AW), .CTRL_W (CTRL_W), .ALU_W (ALU_W),
        .DMEM_W (DMEM_W), .LINK_BUBBLES (LB), .NOP_ALU (NOP), .LINK_REG (31)
    ) dut (
        .clk (clk), .reset (reset), .stall_in (stall_in), .flush (flush),
        .in_valid (in_valid), .ctrl_in (ctrl_in), .alu_ctrl_in (alu_ctrl_in),
        .busA_in (busA_in), .busB_in (busB_in), .imm_in (imm_in),
        .dmem_info_in (dmem_info_in), .rs_in (rs_in), .rt_in (rt_in),
        .uses_rt_in (uses_rt_in), .wr_reg_in (wr_reg_in), .is_link_in (is_link_in),
        .is_load_in (is_load_in), .ctrl_out (ctrl_out), .alu_ctrl_out (alu_ctrl_out),
        .busA_out (busA_out), .busB_out (busB_out), .imm_out (imm_out),
        .dmem_info_out (dmem_info_out), .wr_reg_out (wr_reg_out),
        .is_load_out (is_load_out), .valid_out (valid_out), .lock_if (lock_if)
    );

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [ALU_W-1:0]  alu;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [DMEM_W-1:0] dmem;
        logic [REG_AW-1:0] wr;
        logic              ld;
        logic              v;
    } slot_t;

    slot_t obs;
    assign obs = {ctrl_out, alu_ctrl_out, busA_out, busB_out, imm_out,
                  dmem_info_out, wr_reg_out, is_load_out, valid_out};

    // Reference model: the slot EX should see plus the bubbles still owed
    slot_t m_out;
    int    m_bubbles = 0;
    int    checks    = 0;
    int    errors    = 0;

    task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic bit m_hazard();
        return (m_bubbles == 0) && m_out.ld && m_out.v && (m_out.wr != 0) &&
               ((m_out.wr == rs_in) || (uses_rt_in && (m_out.wr == rt_in)));
    endfunction

    task automatic m_nop();
        m_out.ctrl = '0;   m_out.alu = NOP;  m_out.wr = '0;
        m_out.ld   = 1'b0; m_out.v   = 1'b0;
        m_out.a    = busA_in; m_out.b = busB_in; m_out.imm = imm_in;
        m_out.dmem = dmem_info_in;
    endtask

    task automatic m_clock();
        bit hz;
        hz = m_hazard();
        if (reset) begin
            m_out     = '0;
            m_out.alu = NOP;
            m_bubbles = 0;
        end else if (flush) begin
            m_nop();
            m_bubbles = 0;
        end else if (!stall_in) begin
            if (m_bubbles > 0) begin
                m_nop();
                m_bubbles--;
            end else if (hz || !in_valid) begin
                m_nop();
            end else begin
                m_out.ctrl = ctrl_in;  m_out.alu = alu_ctrl_in;
                m_out.a    = busA_in;  m_out.b   = busB_in;
                m_out.imm  = imm_in;   m_out.dmem = dmem_info_in;
                m_out.wr   = is_link_in ? 5'd31 : wr_reg_in;
                m_out.ld   = is_load_in;
                m_out.v    = 1'b1;
                if (is_link_in) m_bubbles = LB;
            end
        end
    endtask

    // One clock: check lock_if with settled inputs, clock, check the slot
    task automatic step(input bit chk_lock);
        #1;
        if (chk_lock) check("lock_if", lock_if, (m_bubbles > 0) || m_hazard());
        @(posedge clk);
        m_clock();
        @(negedge clk);
        check("slot", obs, m_out);
    endtask

    task automatic drive(input bit v, input int wr, input int rs, input int rt,
                         input bit urt, input bit lnk, input bit ld);
        in_valid     = v;
        wr_reg_in    = REG_AW'(wr);
        rs_in        = REG_AW'(rs);
        rt_in        = REG_AW'(rt);
        uses_rt_in   = urt;
        is_link_in   = lnk;
        is_load_in   = ld;
        ctrl_in      = CTRL_W'($urandom);
        alu_ctrl_in  = ALU_W'($urandom);
        busA_in      = $urandom;
        busB_in      = $urandom;
        imm_in       = $urandom;
        dmem_info_in = DMEM_W'($urandom);
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step(0);
        step(1);
        reset = 1'b0;
        check("rst_alu", alu_ctrl_out, NOP);
        check("rst_valid", valid_out, 1'b0);
        check("rst_wr", wr_reg_out, 5'd0);
        check("rst_ctrl", ctrl_out, 9'd0);

        // Plain ALU op
        drive(1, 3, 1, 2, 1, 0, 0);
        step(1);
        check("add_wr", wr_reg_out, 5'd3);
        check("add_valid", valid_out, 1'b1);

        // JAL: link register, then LB bubbles with fetch locked
        drive(1, 7, 0, 0, 0, 1, 0);
        step(1);
        check("jal_wr", wr_reg_out, 5'd31);
        check("jal_valid", valid_out, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("jal_lock1", lock_if, 1'b1);
        step(1);
        check("jal_b1_valid", valid_out, 1'b0);
        check("jal_b1_alu", alu_ctrl_out, NOP);
        step(1);
        check("jal_b2_valid", valid_out, 1'b0);
        #1 check("jal_unlock", lock_if, 1'b0);

        // Load-use on rs: exactly one bubble, then the consumer
        drive(1, 5, 1, 2, 1, 0, 1);
        step(1);
        drive(1, 6, 5, 1, 1, 0, 0);
        #1 check("lu_lock", lock_if, 1'b1);
        step(1);
        check("lu_bubble", valid_out, 1'b0);
        step(1);
        check("lu_retry_wr", wr_reg_out, 5'd6);
        check("lu_retry_valid", valid_out, 1'b1);

        // Load to r0 never stalls
        drive(1, 0, 1, 2, 1, 0, 1);
        step(1);
        drive(1, 4, 0, 0, 1, 0, 0);
        #1 check("r0_lock", lock_if, 1'b0);
        step(1);
        check("r0_wr", wr_reg_out, 5'd4);

        // Flush during the first link bubble aborts the sequence
        drive(1, 7, 0, 0, 0, 1, 0);
        step(1);
        flush = 1'b1;
        drive(1, 8, 0, 0, 0, 0, 0);
        step(1);
        flush = 1'b0;
        check("fl_valid", valid_out, 1'b0);
        #1 check("fl_lock", lock_if, 1'b0);
        drive(1, 9, 1, 1, 0, 0, 0);
        step(1);
        check("fl_next_wr", wr_reg_out, 5'd9);

        // Stall for three cycles right after JAL: everything holds
        drive(1, 7, 0, 0, 0, 1, 0);
        step(1);
        stall_in = 1'b1;
        drive(1, 10, 1, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("st_wr", wr_reg_out, 5'd31);
            check("st_valid", valid_out, 1'b1);
        end
        stall_in = 1'b0;
        step(1);
        check("st_b1", valid_out, 1'b0);
        step(1);
        check("st_b2", valid_out, 1'b0);
        step(1);
        check("st_after_wr", wr_reg_out, 5'd10);

        // Reset in the middle of LINK leaves no residual bubbles
        drive(1, 7, 0, 0, 0, 1, 0);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        #1 check("rl_lock", lock_if, 1'b0);
        drive(1, 11, 1, 2, 0, 0, 0);
        step(1);
        check("rl_wr", wr_reg_out, 5'd11);

        // Randomized traffic with small register numbers to provoke hazards
        for (int n = 0; n < 500; n++) begin
            reset    = ($urandom_range(0, 99) < 2);
            flush    = ($urandom_range(0, 99) < 5);
            stall_in = ($urandom_range(0, 99) < 15);
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_id_pipe_ctrl
`default_nettype wire
